game_controller: RTL and testbench
==================================

# game_controller

Top-level game-flow state machine that produces the status signals the scoreboard and play-field blocks consume: `game_state`, `current_round`, `lives_remaining` and `aliens_remaining`. It counts alien kills and player hits reported by the collision logic, sequences start screen, round intro, play and game over, and emits single-cycle pulses to respawn the alien grid and the player. It sits beside the scoreboard on `pixel_clk` and uses `fsync` as its frame tick.

## Interface
Parameters:
- `NUM_ROWS`, `NUM_COLS`: from `params`; total aliens `TOTAL = NUM_ROWS*NUM_COLS`.
- `NUM_ROUNDS`, default 4: rounds per game, range 1–4.
- `START_LIVES`, default 3: lives at game start, range 1–3.
- `INTRO_FRAMES`, default 120: frames spent in ROUND_INTRO, ≥1.
- `OVER_FRAMES`, default 180: frames spent in GAME_OVER, ≥1.

Ports:
- `pixel_clk` in 1: the only clock.
- `rst` in 1: reset, synchronous and active-high.
- `fsync` in 1: one-cycle pulse per frame.
- `start_btn` in 1: level, already synchronised; edge-detected internally.
- `alien_hit` in 1: one-cycle pulse per alien destroyed.
- `player_hit` in 1: one-cycle pulse per player death.
- `game_state` out 2: 00 START_SCREEN, 01 ROUND_INTRO, 10 PLAY_GAME, 11 GAME_OVER.
- `current_round` out 2: zero-based round index.
- `lives_remaining` out 2: 0–3.
- `aliens_remaining` out W = $clog2(TOTAL+1): aliens alive this round.
- `game_won` out 1: high in GAME_OVER if the final round was cleared.
- `round_start` out 1: one-cycle pulse; the alien grid reloads.
- `player_respawn` out 1: one-cycle pulse; the player returns to spawn.

## Operation
- All outputs are registered. Reset values: `game_state`=00, `current_round`=0, `lives_remaining`=START_LIVES, `aliens_remaining`=TOTAL, `game_won`=0, pulses 0, frame counter 0, button edge register 0.
- Start press = `start_btn` high while its registered copy is low.
- START_SCREEN:
  - On a start press: go to ROUND_INTRO.
  - Load round=0, lives=START_LIVES, aliens=TOTAL; clear `game_won` and the frame counter.
- ROUND_INTRO:
  - Count `fsync` pulses.
  - When the count reaches INTRO_FRAMES: go to PLAY_GAME, pulse `round_start` and `player_respawn` together, clear the counter.
- PLAY_GAME:
  - `alien_hit` decrements `aliens_remaining`, saturating at 0.
  - `player_hit` decrements `lives_remaining`, saturating at 0.
  - A hit with lives > 1 pulses `player_respawn`.
  - A hit with lives == 1 sets lives to 0 and goes to GAME_OVER with `game_won`=0.
  - An `alien_hit` with aliens == 1 (round cleared) and no loss:
    - If `current_round` == NUM_ROUNDS-1: go to GAME_OVER with `game_won`=1.
    - Otherwise: increment the round, reload aliens=TOTAL, go to ROUND_INTRO. Lives carry over.
- Simultaneous `alien_hit` and `player_hit`:
  - Both counters update in the same cycle.
  - If the last life is lost, loss takes priority even when the last alien also died. The result is GAME_OVER with `game_won`=0 and aliens=0.
- GAME_OVER:
  - Count `fsync` pulses.
  - At OVER_FRAMES: go to START_SCREEN and clear the counter.
  - Counters freeze. `game_won` holds until START_SCREEN exits.
- `alien_hit` and `player_hit` are ignored outside PLAY_GAME. Start presses are ignored outside START_SCREEN.
- The frame counter is cleared on every state change. It is wide enough for max(INTRO_FRAMES, OVER_FRAMES).

## Timing
- Every event sampled at edge N shows its effect on the outputs at edge N+1 (latency 1 cycle).
- A start press is a single cycle: `start_btn` going 0→1 at edge N moves the state at N+1. Holding the button does not retrigger.
- ROUND_INTRO → PLAY_GAME happens the cycle after the INTRO_FRAMES-th `fsync`. `round_start` is high for exactly that one cycle.
- `fsync` on the same cycle as a transition is not counted in the new state.
- `rst` has priority over every event in the same cycle. Reset mid-round returns to the reset values at the next edge, and no pulses fire.

## Test plan
- Reset, then start press → `game_state` 00→01, round 0, lives 3, aliens=TOTAL. After 120 `fsync` pulses → state 10 with a 1-cycle `round_start` and `player_respawn`.
- TOTAL `alien_hit` pulses in round 0 → aliens counts down to 0, state 01, round 1, aliens reloaded to TOTAL, lives unchanged.
- 3 `player_hit` pulses → lives 2, 1, 0. `player_respawn` fires after the first two only. State 11, `game_won`=0. After 180 frames → state 00.
- Last alien of round 3 killed → state 11, `game_won`=1. Last alien and last life in the same cycle → state 11, `game_won`=0, aliens 0, lives 0.
- `alien_hit`/`player_hit` during states 00, 01 and 11 → no counter change. Holding `start_btn` high through GAME_OVER into START_SCREEN → no restart until it is released and pressed again.
- `rst` asserted mid-PLAY_GAME with aliens=5 and lives=2 → next cycle all outputs are at their reset values and no pulses fire.

Source files
------------

// File: rtl/game_controller.sv
// Game-flow sequencer: start screen, round intro, play and game over, with
// life/alien bookkeeping and single-cycle respawn pulses for the play field.
module game_controller #(
  parameter int NUM_ROWS     = 5,
  parameter int NUM_COLS     = 11,
  parameter int NUM_ROUNDS   = 4,
  parameter int START_LIVES  = 3,
  parameter int INTRO_FRAMES = 120,
  parameter int OVER_FRAMES  = 180,
  localparam int TOTAL       = NUM_ROWS * NUM_COLS,
  localparam int W           = $clog2(TOTAL + 1)
) (
  input  logic         pixel_clk,
  input  logic         rst,
  input  logic         fsync,
  input  logic         start_btn,
  input  logic         alien_hit,
  input  logic         player_hit,
  output logic [1:0]   game_state,
  output logic [1:0]   current_round,
  output logic [1:0]   lives_remaining,
  output logic [W-1:0] aliens_remaining,
  output logic         game_won,
  output logic         round_start,
  output logic         player_respawn
);

  localparam int MAXF = (INTRO_FRAMES > OVER_FRAMES) ? INTRO_FRAMES : OVER_FRAMES;
  localparam int FW   = $clog2(MAXF + 1);

  localparam logic [FW-1:0] INTRO_LAST = FW'(INTRO_FRAMES - 1);
  localparam logic [FW-1:0] OVER_LAST  = FW'(OVER_FRAMES - 1);
  localparam logic [1:0]    LAST_ROUND = 2'(NUM_ROUNDS - 1);
  localparam logic [1:0]    LIVES0     = 2'(START_LIVES);
  localparam logic [W-1:0]  ALIENS0    = W'(TOTAL);

  typedef enum logic [1:0] {
    ST_START = 2'b00,
    ST_INTRO = 2'b01,
    ST_PLAY  = 2'b10,
    ST_OVER  = 2'b11
  } state_t;

  state_t        r_state, w_state_nx;
  logic [1:0]    r_round, w_round_nx;
  logic [1:0]    r_lives, w_lives_nx;
  logic [W-1:0]  r_aliens, w_aliens_nx;
  logic          r_won, w_won_nx;
  logic          r_rs, w_rs_nx;
  logic          r_pr, w_pr_nx;
  logic [FW-1:0] r_cnt, w_cnt_nx;
  logic          r_btn;
  logic          w_press;
  logic          w_loss;
  logic          w_cleared;

  assign w_press   = start_btn & ~r_btn;
  assign w_loss    = player_hit & (r_lives == 2'd1);
  assign w_cleared = alien_hit & (r_aliens == W'(1));

  always_comb begin
    w_state_nx  = r_state;
    w_round_nx  = r_round;
    w_lives_nx  = r_lives;
    w_aliens_nx = r_aliens;
    w_won_nx    = r_won;
    w_rs_nx     = 1'b0;
    w_pr_nx     = 1'b0;
    w_cnt_nx    = r_cnt;
    case (r_state)
      ST_START: begin
        if (w_press) begin
          w_state_nx  = ST_INTRO;
          w_round_nx  = '0;
          w_lives_nx  = LIVES0;
          w_aliens_nx = ALIENS0;
          w_won_nx    = 1'b0;
          w_cnt_nx    = '0;
        end
      end
      ST_INTRO: begin
        if (fsync) begin
          if (r_cnt == INTRO_LAST) begin
            w_state_nx = ST_PLAY;
            w_rs_nx    = 1'b1;
            w_pr_nx    = 1'b1;
            w_cnt_nx   = '0;
          end else begin
            w_cnt_nx = r_cnt + 1'b1;
          end
        end
      end
      ST_PLAY: begin
        if (alien_hit && r_aliens != '0)
          w_aliens_nx = r_aliens - 1'b1;
        if (player_hit && r_lives != '0)
          w_lives_nx = r_lives - 1'b1;
        // Losing the last life outranks clearing the round in the same cycle.
        if (w_loss) begin
          w_state_nx = ST_OVER;
          w_won_nx   = 1'b0;
          w_cnt_nx   = '0;
        end else begin
          if (player_hit)
            w_pr_nx = 1'b1;
          if (w_cleared) begin
            w_cnt_nx = '0;
            if (r_round == LAST_ROUND) begin
              w_state_nx = ST_OVER;
              w_won_nx   = 1'b1;
            end else begin
              w_state_nx  = ST_INTRO;
              w_round_nx  = r_round + 1'b1;
              w_aliens_nx = ALIENS0;
            end
          end
        end
      end
      ST_OVER: begin
        if (fsync) begin
          if (r_cnt == OVER_LAST) begin
            w_state_nx = ST_START;
            w_cnt_nx   = '0;
          end else begin
            w_cnt_nx = r_cnt + 1'b1;
          end
        end
      end
      default: w_state_nx = ST_START;
    endcase
  end

  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      r_state  <= ST_START;
      r_round  <= '0;
      r_lives  <= LIVES0;
      r_aliens <= ALIENS0;
      r_won    <= 1'b0;
      r_rs     <= 1'b0;
      r_pr     <= 1'b0;
      r_cnt    <= '0;
      r_btn    <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_round  <= w_round_nx;
      r_lives  <= w_lives_nx;
      r_aliens <= w_aliens_nx;
      r_won    <= w_won_nx;
      r_rs     <= w_rs_nx;
      r_pr     <= w_pr_nx;
      r_cnt    <= w_cnt_nx;
      r_btn    <= start_btn;
    end
  end

  assign game_state       = r_state;
  assign current_round    = r_round;
  assign lives_remaining  = r_lives;
  assign aliens_remaining = r_aliens;
  assign game_won         = r_won;
  assign round_start      = r_rs;
  assign player_respawn   = r_pr;

endmodule

// File: tb/tb_game_controller.sv
// Directed bench for game_controller with a 2x3 grid and short frame counts;
// expected values are hand-derived for each step.
module tb_game_controller;

  localparam int ROWS  = 2;
  localparam int COLS  = 3;
  localparam int TOT   = ROWS * COLS;
  localparam int INTRO = 3;
  localparam int OVER  = 4;
  localparam int AW    = $clog2(TOT + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          fsync = 1'b0;
  logic          start_btn = 1'b0;
  logic          alien_hit = 1'b0;
  logic          player_hit = 1'b0;
  logic [1:0]    game_state;
  logic [1:0]    current_round;
  logic [1:0]    lives_remaining;
  logic [AW-1:0] aliens_remaining;
  logic          game_won;
  logic          round_start;
  logic          player_respawn;

  int n_checks = 0;
  int n_pass   = 0;

  game_controller #(
    .NUM_ROWS(ROWS), .NUM_COLS(COLS), .NUM_ROUNDS(4), .START_LIVES(3),
    .INTRO_FRAMES(INTRO), .OVER_FRAMES(OVER)
  ) dut (
    .pixel_clk(clk), .rst(rst), .fsync(fsync), .start_btn(start_btn),
    .alien_hit(alien_hit), .player_hit(player_hit),
    .game_state(game_state), .current_round(current_round),
    .lives_remaining(lives_remaining), .aliens_remaining(aliens_remaining),
    .game_won(game_won), .round_start(round_start),
    .player_respawn(player_respawn)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fsync_n(input int n);
    for (int i = 0; i < n; i++) begin
      fsync = 1'b1; tick(); fsync = 1'b0; tick();
    end
  endtask

  task automatic kill(input int n);
    for (int i = 0; i < n; i++) begin
      alien_hit = 1'b1; tick(); alien_hit = 1'b0;
    end
  endtask

  task automatic hit_player();
    player_hit = 1'b1; tick(); player_hit = 1'b0;
  endtask

  task automatic intro_done(input string tag);
    fsync_n(INTRO - 1);
    check({tag, "_still_intro"}, game_state, 1);
    fsync = 1'b1; tick(); fsync = 1'b0;
    check({tag, "_play"}, game_state, 2);
    check({tag, "_rs"}, round_start, 1);
    check({tag, "_pr"}, player_respawn, 1);
    tick();
    check({tag, "_rs_drop"}, round_start, 0);
    check({tag, "_pr_drop"}, player_respawn, 0);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_state"}, game_state, 0);
    check({tag, "_round"}, current_round, 0);
    check({tag, "_lives"}, lives_remaining, 3);
    check({tag, "_aliens"}, aliens_remaining, TOT);
    check({tag, "_won"}, game_won, 0);
    check({tag, "_rs"}, round_start, 0);
    check({tag, "_pr"}, player_respawn, 0);
  endtask

  initial begin
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    check_reset("reset");

    // hits in START_SCREEN are ignored
    alien_hit = 1'b1; player_hit = 1'b1; tick(); alien_hit = 1'b0; player_hit = 1'b0;
    check("start_ign_lives", lives_remaining, 3);
    check("start_ign_aliens", aliens_remaining, TOT);
    check("start_ign_state", game_state, 0);

    start_btn = 1'b1; tick();
    check("press_state", game_state, 1);
    check("press_round", current_round, 0);
    check("press_aliens", aliens_remaining, TOT);

    alien_hit = 1'b1; player_hit = 1'b1; tick(); alien_hit = 1'b0; player_hit = 1'b0;
    check("intro_ign_aliens", aliens_remaining, TOT);
    check("intro_ign_lives", lives_remaining, 3);
    start_btn = 1'b0;

    intro_done("r0");
    kill(TOT - 1);
    check("r0_aliens_1", aliens_remaining, 1);
    check("r0_state_play", game_state, 2);
    kill(1);
    check("r0_clear_state", game_state, 1);
    check("r0_clear_round", current_round, 1);
    check("r0_clear_aliens", aliens_remaining, TOT);
    check("r0_clear_lives", lives_remaining, 3);

    intro_done("r1");
    hit_player();
    check("r1_lives2", lives_remaining, 2);
    check("r1_resp", player_respawn, 1);
    tick();
    check("r1_resp_drop", player_respawn, 0);
    alien_hit = 1'b1; player_hit = 1'b1; tick(); alien_hit = 1'b0; player_hit = 1'b0;
    check("r1_both_lives", lives_remaining, 1);
    check("r1_both_aliens", aliens_remaining, TOT - 1);
    check("r1_both_state", game_state, 2);
    check("r1_both_resp", player_respawn, 1);
    kill(TOT - 1);
    check("r1_clear_state", game_state, 1);
    check("r1_clear_round", current_round, 2);
    check("r1_clear_lives", lives_remaining, 1);

    intro_done("r2");
    kill(TOT);
    check("r2_clear_round", current_round, 3);
    check("r2_clear_state", game_state, 1);

    intro_done("r3");
    kill(TOT);
    check("win_state", game_state, 3);
    check("win_flag", game_won, 1);
    check("win_aliens", aliens_remaining, 0);
    check("win_lives", lives_remaining, 1);

    alien_hit = 1'b1; player_hit = 1'b1; tick(); alien_hit = 1'b0; player_hit = 1'b0;
    check("over_ign_lives", lives_remaining, 1);
    check("over_ign_state", game_state, 3);

    // button held through GAME_OVER must not restart the game
    start_btn = 1'b1; tick();
    fsync_n(OVER - 1);
    check("over_wait", game_state, 3);
    fsync = 1'b1; tick(); fsync = 1'b0;
    check("over_exit", game_state, 0);
    check("over_won_hold", game_won, 1);
    tick(); tick();
    check("held_no_restart", game_state, 0);
    start_btn = 1'b0; tick();
    check("released", game_state, 0);
    start_btn = 1'b1; tick(); start_btn = 1'b0;
    check("repress_state", game_state, 1);
    check("repress_won", game_won, 0);
    check("repress_lives", lives_remaining, 3);
    check("repress_round", current_round, 0);
    check("repress_aliens", aliens_remaining, TOT);

    intro_done("g2");
    hit_player();
    check("g2_lives2", lives_remaining, 2);
    check("g2_resp1", player_respawn, 1);
    hit_player();
    check("g2_lives1", lives_remaining, 1);
    check("g2_resp2", player_respawn, 1);
    kill(TOT - 1);
    check("g2_aliens1", aliens_remaining, 1);
    alien_hit = 1'b1; player_hit = 1'b1; tick(); alien_hit = 1'b0; player_hit = 1'b0;
    check("loss_state", game_state, 3);
    check("loss_won", game_won, 0);
    check("loss_aliens", aliens_remaining, 0);
    check("loss_lives", lives_remaining, 0);
    check("loss_no_resp", player_respawn, 0);
    fsync_n(OVER);
    check("loss_to_start", game_state, 0);

    start_btn = 1'b1; tick(); start_btn = 1'b0;
    check("g3_state", game_state, 1);
    intro_done("g3");
    hit_player();
    kill(1);
    check("g3_aliens", aliens_remaining, TOT - 1);
    check("g3_lives", lives_remaining, 2);
    rst = 1'b1; player_hit = 1'b1; alien_hit = 1'b1; tick();
    rst = 1'b0; player_hit = 1'b0; alien_hit = 1'b0;
    check_reset("midrst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
